// File: rtl/linefillbuffer_pkg.sv
// Shared cache-fill definitions: FSM state encoding and the line/beat geometry
// helpers that the bus interface and the cache data path must agree on.
package linefillbuffer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } lfb_state_e;

  localparam int LINELEN_DFLT = 512;
  localparam int AHBW_DFLT    = 64;

  function automatic int beats_per_line(input int linelen, input int ahbw);
    return linelen / ahbw;
  endfunction

  function automatic int beat_w(input int linelen, input int ahbw);
    return $clog2(linelen / ahbw);
  endfunction

  localparam int BEATSPERLINE = beats_per_line(LINELEN_DFLT, AHBW_DFLT);
  localparam int BEATW        = beat_w(LINELEN_DFLT, AHBW_DFLT);

endpackage

// File: rtl/linefillbeatctr.sv
// Beat bookkeeping for a line fill: a loadable write pointer that wraps
// modulo the line, plus a beat count with a last-beat flag.
module linefillbeatctr #(
  parameter  int BEATSPERLINE = 8,
  localparam int BEATW        = $clog2(BEATSPERLINE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [BEATW-1:0] loadptr,
  input  logic             inc,
  output logic [BEATW-1:0] ptr,
  output logic [BEATW:0]   cnt,
  output logic             lastbeat
);

  localparam logic [BEATW:0] LASTCNT = (BEATW+1)'(BEATSPERLINE - 1);

  // NOTE: sequential state is always updated with <= so every flop samples
  // pre-edge values; blocking = here would create order-dependent races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
      cnt <= '0;
    end else if (load) begin
      ptr <= loadptr;
      cnt <= '0;
    end else if (inc) begin
      // Power-of-two line length, so natural overflow is the wrap-around.
      ptr <= ptr + BEATW'(1);
      cnt <= cnt + (BEATW+1)'(1);
    end
  end

  assign lastbeat = (cnt == LASTCNT);

endmodule

// File: rtl/linefillbuffer.sv
// Line fill buffer: collects a critical-word-first burst of bus beats into a
// full cache line and flags critical-beat and whole-line availability.
module linefillbuffer
  import linefillbuffer_pkg::*;
#(
  parameter  int LINELEN      = LINELEN_DFLT,
  parameter  int AHBW         = AHBW_DFLT,
  localparam int BEATSPERLINE = beats_per_line(LINELEN, AHBW),
  localparam int BEATW        = beat_w(LINELEN, AHBW)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    Start,
  input  logic [BEATW-1:0]        StartBeat,
  input  logic                    BeatValid,
  input  logic [AHBW-1:0]         BeatData,
  input  logic                    Abort,
  input  logic                    Consume,
  output logic [LINELEN-1:0]      ReadDataLine,
  output logic [BEATSPERLINE-1:0] BeatMask,
  output logic                    CritBeatValid,
  output logic                    LineValid,
  output logic                    Busy,
  output logic                    Overrun
);

  lfb_state_e       state, nextstate;
  logic             load;
  logic             write;
  logic [BEATW-1:0] wrptr;
  logic [BEATW:0]   beatcnt;
  logic             lastbeat;

  linefillbeatctr #(.BEATSPERLINE(BEATSPERLINE)) u_beatctr (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .loadptr  (StartBeat),
    .inc      (write),
    .ptr      (wrptr),
    .cnt      (beatcnt),
    .lastbeat (lastbeat)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextstate;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    nextstate = state;
    load      = 1'b0;
    write     = 1'b0;
    if (Abort) begin
      nextstate = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (Start) begin
            load      = 1'b1;
            nextstate = FILL;
          end
        end
        FILL: begin
          if (BeatValid) begin
            write = 1'b1;
            if (lastbeat) nextstate = DONE;
          end
        end
        DONE: begin
          if (Consume) begin
            if (Start) begin
              load      = 1'b1;
              nextstate = FILL;
            end else begin
              nextstate = IDLE;
            end
          end
        end
        default: nextstate = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      BeatMask      <= '0;
      CritBeatValid <= 1'b0;
      Overrun       <= 1'b0;
    end else begin
      if (Abort || load)  BeatMask        <= '0;
      else if (write)     BeatMask[wrptr] <= 1'b1;
      // Write is already suppressed by Abort, which cancels a pending pulse.
      CritBeatValid <= write && (beatcnt == '0);
      Overrun       <= BeatValid && (state != FILL);
    end
  end

  // NOTE: the line storage is reset because the line must read as zero out
  // of reset; it is otherwise never cleared, so stale beats stay visible.
  for (genvar k = 0; k < BEATSPERLINE; k++) begin : g_slot
    logic [AHBW-1:0] slot;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)                            slot <= '0;
      else if (write && wrptr == BEATW'(k))  slot <= BeatData;
    end
    assign ReadDataLine[k*AHBW +: AHBW] = slot;
  end

  assign Busy      = (state == FILL);
  assign LineValid = (state == DONE);

endmodule

// File: tb/tb_linefillbuffer.sv
// Self-checking bench for linefillbuffer: table-driven aligned fill, directed
// corner sequences and randomized traffic against a behavioural line model.
module tb_linefillbuffer;
  import linefillbuffer_pkg::*;

  localparam int NB = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         Start, BeatValid, Abort, Consume;
  logic [2:0]   StartBeat;
  logic [63:0]  BeatData;
  logic [511:0] ReadDataLine;
  logic [7:0]   BeatMask;
  logic         CritBeatValid, LineValid, Busy, Overrun;

  always #5 clk = ~clk;

  linefillbuffer dut (
    .clk           (clk),
    .reset         (reset),
    .Start         (Start),
    .StartBeat     (StartBeat),
    .BeatValid     (BeatValid),
    .BeatData      (BeatData),
    .Abort         (Abort),
    .Consume       (Consume),
    .ReadDataLine  (ReadDataLine),
    .BeatMask      (BeatMask),
    .CritBeatValid (CritBeatValid),
    .LineValid     (LineValid),
    .Busy          (Busy),
    .Overrun       (Overrun)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Behavioural model: a line is "filling" or "held"; beat n of a fill lands in
  // slot (first + n) mod 8.
  bit          m_filling, m_held, m_crit, m_ovr;
  logic [63:0] m_slot[NB];
  logic [7:0]  m_mask;
  int          m_first, m_cnt;

  task automatic model_reset();
    m_filling = 0; m_held = 0; m_crit = 0; m_ovr = 0;
    m_mask = '0; m_first = 0; m_cnt = 0;
    for (int i = 0; i < NB; i++) m_slot[i] = '0;
  endtask

  task automatic model_step(input logic st, input logic [2:0] sb, input logic bv,
                            input logic [63:0] d, input logic ab, input logic co);
    int s;
    m_ovr  = bv && !m_filling;
    m_crit = 0;
    if (ab) begin
      m_filling = 0; m_held = 0; m_mask = '0;
    end else if (m_filling) begin
      if (bv) begin
        s = (m_first + m_cnt) % NB;
        m_slot[s] = d;
        m_mask[s] = 1'b1;
        m_crit = (m_cnt == 0);
        m_cnt++;
        if (m_cnt == NB) begin
          m_filling = 0; m_held = 1;
        end
      end
    end else if (!m_held || co) begin
      m_held = 0;
      if (st) begin
        m_filling = 1; m_first = int'(sb); m_cnt = 0; m_mask = '0;
      end
    end
  endtask

  function automatic logic [511:0] model_line();
    logic [511:0] l;
    for (int i = 0; i < NB; i++) l[i*64 +: 64] = m_slot[i];
    return l;
  endfunction

  task automatic compare_model();
    check("model Busy", Busy, m_filling);
    check("model LineValid", LineValid, m_held);
    check("model BeatMask", BeatMask, m_mask);
    check("model CritBeatValid", CritBeatValid, m_crit);
    check("model Overrun", Overrun, m_ovr);
    check("model ReadDataLine", ReadDataLine, model_line());
  endtask

  task automatic step(input logic st, input logic [2:0] sb, input logic bv,
                      input logic [63:0] d, input logic ab, input logic co);
    Start = st; StartBeat = sb; BeatValid = bv; BeatData = d; Abort = ab; Consume = co;
    @(posedge clk);
    model_step(st, sb, bv, d, ab, co);
    #1;
    compare_model();
    Start = 0; StartBeat = '0; BeatValid = 0; BeatData = '0; Abort = 0; Consume = 0;
  endtask

  typedef struct {
    logic        st;
    logic [2:0]  sb;
    logic        bv;
    logic [63:0] d;
    logic        co;
    logic [7:0]  emask;
    logic        elv, ebusy, ecrit, eovr;
  } vec_t;

  function automatic vec_t mkv(input logic st, input logic [2:0] sb, input logic bv,
                               input logic [63:0] d, input logic co, input logic [7:0] emask,
                               input logic elv, input logic ebusy, input logic ecrit,
                               input logic eovr);
    vec_t v;
    v.st = st; v.sb = sb; v.bv = bv; v.d = d; v.co = co; v.emask = emask;
    v.elv = elv; v.ebusy = ebusy; v.ecrit = ecrit; v.eovr = eovr;
    return v;
  endfunction

  vec_t tbl[12];

  initial begin
    logic [63:0] kk;
    logic [7:0]  wm[NB];
    logic [7:0]  b;
    logic [63:0] bdat[NB];

    // Aligned fill: Start, 8 beats of 0x1111..*k, a stray beat in DONE,
    // Consume, then a stray beat in IDLE.
    tbl[0] = mkv(1, 3'd0, 0, 64'h0, 0, 8'h00, 0, 1, 0, 0);
    for (int k = 0; k < NB; k++) begin
      kk = 64'(k);
      tbl[k+1] = mkv(0, 3'd0, 1, 64'h1111111111111111 * kk, 0,
                     8'((1 << (k+1)) - 1), k == 7, k != 7, k == 0, 0);
    end
    tbl[9]  = mkv(0, 3'd0, 1, 64'hDEADDEADDEADDEAD, 0, 8'hFF, 1, 0, 0, 1);
    tbl[10] = mkv(0, 3'd0, 0, 64'h0, 1, 8'hFF, 0, 0, 0, 0);
    tbl[11] = mkv(0, 3'd0, 1, 64'hBEEFBEEFBEEFBEEF, 0, 8'hFF, 0, 0, 0, 1);

    wm[0] = 8'h20; wm[1] = 8'h60; wm[2] = 8'hE0; wm[3] = 8'hE1;
    wm[4] = 8'hE3; wm[5] = 8'hE7; wm[6] = 8'hEF; wm[7] = 8'hFF;

    Start = 0; StartBeat = '0; BeatValid = 0; BeatData = '0; Abort = 0; Consume = 0;
    reset = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset ReadDataLine", ReadDataLine, 512'h0);
    check("reset BeatMask", BeatMask, 8'h00);
    check("reset LineValid", LineValid, 1'b0);
    check("reset Busy", Busy, 1'b0);
    @(negedge clk) reset = 1;

    // Table-driven aligned fill
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].st, tbl[i].sb, tbl[i].bv, tbl[i].d, 1'b0, tbl[i].co);
      check($sformatf("tbl[%0d] BeatMask", i), BeatMask, tbl[i].emask);
      check($sformatf("tbl[%0d] LineValid", i), LineValid, tbl[i].elv);
      check($sformatf("tbl[%0d] Busy", i), Busy, tbl[i].ebusy);
      check($sformatf("tbl[%0d] CritBeatValid", i), CritBeatValid, tbl[i].ecrit);
      check($sformatf("tbl[%0d] Overrun", i), Overrun, tbl[i].eovr);
    end
    for (int k = 0; k < NB; k++) begin
      kk = 64'(k);
      check($sformatf("aligned slot%0d", k), ReadDataLine[k*64 +: 64], 64'h1111111111111111 * kk);
    end

    // Reset mid-fill after three beats
    step(1, 3'd2, 0, 64'h0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 3'd0, 1, {$urandom, $urandom}, 0, 0);
    #2 reset = 0;
    #1;
    check("midreset ReadDataLine", ReadDataLine, 512'h0);
    check("midreset BeatMask", BeatMask, 8'h00);
    check("midreset Busy", Busy, 1'b0);
    check("midreset LineValid", LineValid, 1'b0);
    check("midreset Overrun", Overrun, 1'b0);
    model_reset();
    @(negedge clk) reset = 1;

    // Wrap fill from beat 5 with idle gaps
    step(1, 3'd5, 0, 64'h0, 0, 0);
    for (int i = 0; i < NB; i++) begin
      repeat ($urandom_range(0, 2)) step(0, 3'd0, 0, 64'h0, 0, 0);
      b = 8'hA1 + 8'(i);
      step(0, 3'd0, 1, {8{b}}, 0, 0);
      check($sformatf("wrap mask%0d", i), BeatMask, wm[i]);
    end
    for (int i = 0; i < NB; i++) begin
      b = 8'hA1 + 8'(i);
      check($sformatf("wrap slot%0d", (5 + i) % NB), ReadDataLine[((5 + i) % NB)*64 +: 64], {8{b}});
    end
    check("wrap LineValid", LineValid, 1'b1);
    step(0, 3'd0, 0, 64'h0, 0, 1);

    // Abort after 4 beats with BeatValid and Start in the same cycle
    step(1, 3'd2, 0, 64'h0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 3'd0, 1, {$urandom, $urandom}, 0, 0);
    step(1, 3'd0, 1, 64'h5555555555555555, 1, 0);
    check("abort Busy", Busy, 1'b0);
    check("abort BeatMask", BeatMask, 8'h00);
    check("abort LineValid", LineValid, 1'b0);
    check("abort CritBeatValid", CritBeatValid, 1'b0);
    step(0, 3'd0, 0, 64'h0, 0, 0);
    check("abort idle Busy", Busy, 1'b0);

    // Abort on the critical beat cancels the pending pulse
    step(1, 3'd6, 0, 64'h0, 0, 0);
    step(0, 3'd0, 1, 64'h7777777777777777, 1, 0);
    check("abortcrit CritBeatValid", CritBeatValid, 1'b0);
    check("abortcrit BeatMask", BeatMask, 8'h00);

    // Back-to-back: Consume+Start in DONE
    step(1, 3'd0, 0, 64'h0, 0, 0);
    for (int i = 0; i < NB; i++) step(0, 3'd0, 1, {$urandom, $urandom}, 0, 0);
    check("b2b first LineValid", LineValid, 1'b1);
    step(1, 3'd3, 0, 64'h0, 0, 1);
    check("b2b Busy", Busy, 1'b1);
    check("b2b LineValid", LineValid, 1'b0);
    check("b2b BeatMask", BeatMask, 8'h00);
    for (int i = 0; i < NB; i++) begin
      bdat[i] = {$urandom, $urandom};
      step(0, 3'd0, 1, bdat[i], 0, 0);
    end
    for (int i = 0; i < NB; i++)
      check($sformatf("b2b slot%0d", (3 + i) % NB), ReadDataLine[((3 + i) % NB)*64 +: 64], bdat[i]);
    check("b2b LineValid", LineValid, 1'b1);
    check("b2b BeatMask full", BeatMask, 8'hFF);

    // Stray beat in DONE, then in IDLE
    step(0, 3'd0, 1, 64'hCAFECAFECAFECAFE, 0, 0);
    check("stray done Overrun", Overrun, 1'b1);
    step(0, 3'd0, 0, 64'h0, 0, 1);
    check("stray done Overrun drop", Overrun, 1'b0);
    step(0, 3'd0, 1, 64'hF00DF00DF00DF00D, 0, 0);
    check("stray idle Overrun", Overrun, 1'b1);
    check("stray idle BeatMask", BeatMask, 8'hFF);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 2) == 0, 3'($urandom), $urandom_range(0, 1) == 1,
           {$urandom, $urandom}, $urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/linefillbuffer.md
# linefillbuffer

Assembles one cache line from a burst of bus beats and presents it, fully assembled, as the ReadDataLine input of the cache's line-to-word read mux. Sits between the bus interface (AHB beats, critical-word-first wrap bursts) and the cache data path. It tracks which beats have landed and signals when the critical beat and the complete line are available.

## Interface
- LINELEN, 512: cache line width in bits.
- AHBW, 64: beat width in bits. BEATSPERLINE = LINELEN/AHBW must be a power of two and at least 2. BEATW = $clog2(BEATSPERLINE).
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low. Asserted low, it clears all state immediately.
- Start  in  1  begin a fill; sampled only in IDLE, or in DONE together with Consume.
- StartBeat  in  BEATW  index of the critical (first) beat of the burst.
- BeatValid  in  1  BeatData is valid this cycle.
- BeatData  in  AHBW  beat payload.
- Abort  in  1  cancel any fill or drop a held line; highest priority.
- Consume  in  1  downstream has taken the line; honoured only in DONE.
- ReadDataLine  out  LINELEN  assembled line, beat k at bits [k*AHBW +: AHBW].
- BeatMask  out  BEATSPERLINE  bit k = 1 once beat k has been written in the current fill.
- CritBeatValid  out  1  one-cycle pulse, asserted the cycle after the critical beat is written.
- LineValid  out  1  line complete; high throughout DONE.
- Busy  out  1  high in FILL.
- Overrun  out  1  one-cycle pulse, asserted the cycle after a BeatValid that arrives in IDLE or DONE.

## Operation
- States: IDLE, FILL, DONE. Reset state is IDLE.
- IDLE, Start=1, Abort=0: load WrPtr=StartBeat, BeatCnt=0, BeatMask=0, then go to FILL.
- FILL, BeatValid=1:
  - Write BeatData to slot WrPtr and set BeatMask[WrPtr].
  - WrPtr increments modulo BEATSPERLINE, wrapping from BEATSPERLINE-1 to 0.
  - BeatCnt increments. BeatCnt is BEATW+1 bits wide.
- The write of the last beat (BeatCnt == BEATSPERLINE-1 and BeatValid=1) moves the FSM to DONE.
- FILL with BeatValid=0 holds all state. There is no timeout.
- DONE, Consume=1:
  - With Start=0: go to IDLE.
  - With Start=1: go directly to FILL, with the same loads as the IDLE start. This is a back-to-back fill.
- Abort=1 in any state: go to IDLE, clear BeatMask, cancel any pending CritBeatValid. Abort takes priority over Start, Consume and BeatValid in the same cycle.
- Start in FILL is ignored. Start in DONE without Consume is ignored.
- BeatValid in IDLE or DONE is not written and does not change BeatMask. It raises Overrun on the next cycle.
- ReadDataLine holds its contents after Consume and after Abort; it is not cleared except by reset. Only BeatMask and LineValid indicate whether the data is valid.
- Beats whose BeatMask bit is 0 read stale data. Downstream may forward the critical word early by using CritBeatValid together with BeatMask.

## Timing
- Reset values: ReadDataLine=0, BeatMask=0, CritBeatValid=0, LineValid=0, Busy=0, Overrun=0, state=IDLE.
- Start accepted at edge t: Busy=1 from cycle t+1. The first beat can be accepted in cycle t+1.
- A beat presented in cycle c is visible on ReadDataLine and BeatMask in cycle c+1.
- CritBeatValid is high only in cycle c+1, where c is the cycle of the first beat.
- The last beat in cycle c gives LineValid=1 and Busy=0 in cycle c+1.
- Minimum fill time is BEATSPERLINE+1 cycles from Start to LineValid.
- Consume in cycle d gives LineValid=0 in cycle d+1. With a simultaneous Start, Busy=1 in cycle d+1.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared cache package holds:
  - the state typedef (enum logic [1:0] {IDLE, FILL, DONE});
  - the BEATSPERLINE/BEATW helper constants, so the bus interface and the cache agree on them.
- One natural sub-module, linefillbeatctr: a loadable, wrapping BEATW-bit pointer plus a BEATW+1-bit count with a terminal-count flag.
- Data storage is BEATSPERLINE AHBW-wide registers, with write enables decoded from WrPtr.

## Test plan
All scenarios use LINELEN=512 and AHBW=64, so there are 8 beats.
- Reset mid-fill: drop reset after 3 beats -> all outputs 0 immediately, state IDLE.
- Aligned fill: Start with StartBeat=0, then 8 consecutive beats with data 0x1111...×k, k=0..7.
  - ReadDataLine[k*64 +: 64] = 0x1111...×k.
  - LineValid is high exactly 9 cycles after the Start edge.
  - CritBeatValid pulses once, one cycle after beat 0.
- Wrap fill: StartBeat=5, beats A..H with idle gaps of 0–2 cycles.
  - Slots 5,6,7,0,1,2,3,4 hold A..H.
  - BeatMask steps through 0x20, 0x60, 0xE0, 0xE1, ... 0xFF.
- Abort after 4 beats, with BeatValid and Start high in the same cycle -> next cycle IDLE, BeatMask=0, LineValid=0, no CritBeatValid.
- Back-to-back: in DONE, assert Consume+Start with StartBeat=3 -> next cycle Busy=1, LineValid=0, BeatMask=0; the new line completes correctly.
- Stray beats: BeatValid in IDLE and in DONE -> Overrun pulses once per stray beat; ReadDataLine and BeatMask are unchanged.
